mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory responder for the core's load/store path. Consumes the `tMemOp` request issued by the ALU stage and performs byte, half-word or word accesses on an internal synchronous data RAM. Returns load results as a `tRegOp` register write-back and flags misaligned, out-of-range or illegal requests. Sits between the ALU output (`tAluOut.memOp`) and the register-file write port.

## Interface
- `pDepth`, default `cRamDepth` (1024): RAM depth in 32-bit words.
- `pAddrW`, default `$clog2(pDepth)`: word-index width.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `memOpIn`, in, `tMemOp`: request. Bits `read`/`write` act as valid. `addr` is a byte address. `opType` is funct3. `data` is store data. `rdAddr` is the load destination.
- `regOpOut`, out, `tRegOp`: load write-back (`dv`, `addr`, `data`). Registered.
- `stall`, out, 1: registered. High while a load is in flight; upstream holds its next op.
- `memErr`, out, 1: registered one-cycle pulse on a rejected request.
- `errAddr`, out, `cXLEN`: byte address of the last rejected request. Holds until the next error.

## Operation
- States: `IDLE` and `LOAD_WAIT`.
- Requests are sampled only in `IDLE`. In `LOAD_WAIT` any request is ignored.
- Word index is `addr[pAddrW+1:2]`. Byte lane is `addr[1:0]`.
- Rejection checks. Any one of these rejects the request: `memErr`=1 next cycle, `errAddr`=`addr`, no RAM write, no write-back, stay `IDLE`.
  - `read` and `write` both high.
  - `opType` not legal for the direction:
    - loads accept 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
    - stores accept 000 SB, 001 SH, 010 SW.
  - Misaligned: half-word with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Out of range: `addr` ≥ 4·`pDepth`.
- Store in `IDLE`, legal: RAM written at the sampling edge.
  - Byte enables come from size and lane.
  - SB replicates `data[7:0]` to all lanes. SH replicates `data[15:0]`.
  - No write-back. No stall.
- Load in `IDLE`, legal:
  - RAM read issued at the sampling edge.
  - Latch `rdAddr`, `opType`, `addr[1:0]`; go to `LOAD_WAIT`.
- `LOAD_WAIT`, one cycle:
  - Select lane from the RAM word.
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend.
  - Register into `regOpOut`; return to `IDLE`.
- `regOpOut.dv` is a one-cycle pulse. It is forced to 0 when `rdAddr`=0; RAM is still read.
- Neither read nor write set: no action.

## Timing
- Reset values: `regOpOut` = `cRegOp` (all zero), `stall`=0, `memErr`=0, `errAddr`=0, state `IDLE`. RAM contents are not reset.
- Load request presented in cycle 0:
  - cycle 1: `stall`=1;
  - cycle 2: `regOpOut.dv`=1 and `stall`=0; next request accepted in cycle 2.
- Load latency is 2 cycles, throughput 1 load per 2 cycles.
- Stores: 1 per cycle, data visible to a load sampled the following cycle. Back-to-back store→load to the same address returns the new data.
- Error pulse appears the cycle after the rejected request. Back-to-back errors keep `memErr` high and update `errAddr` each cycle.
- Reset during `LOAD_WAIT`:
  - the next cycle shows reset values;
  - the pending load is dropped with no `dv`;
  - completed stores remain in RAM.
- `stall` never depends combinationally on `memOpIn`.

## Structure
- Additions to `corePckg`:
  - load/store funct3 constants: `cLB`, `cLH`, `cLW`, `cLBU`, `cLHU`, `cSB`, `cSH`, `cSW`;
  - state enum `tMemState` {`eMemIdle`, `eMemLoadWait`};
  - struct `tMemErr` {`err`, `addr`}.
- Sub-module `data_ram`:
  - single-port synchronous RAM;
  - 32-bit words, 4 byte-write enables, 1-cycle registered read, read-first on the same-cycle port;
  - depth `pDepth`.
- All lane selection, extension and checks stay in `mem_access_unit`.

## Test plan
- SW 0x80001234 at 0x10, then LW at 0x10 to rd 5 → cycle 2: `regOpOut` = {1, 5, 0x80001234}; `stall` high in cycle 1 only.
- Same word, lane loads:
  - LB at 0x13 → 0xFFFFFF80;
  - LBU at 0x13 → 0x00000080;
  - LH at 0x12 → 0xFFFF8000;
  - LHU at 0x10 → 0x00001234.
- SB 0xAB to 0x11 over 0x00000000, then LW 0x10 → 0x0000AB00; other bytes untouched.
- Rejected requests, each → `memErr` pulse, `errAddr` = request address, no RAM change, no `dv`:
  - LH at 0x21;
  - SW at 0x22;
  - LW at 4·`pDepth`;
  - `opType` 011;
  - read+write together.
- Reset and protocol corners:
  - LW issued, `rst` asserted in `LOAD_WAIT` → no `dv`, outputs at reset values, prior stores still readable;
  - a request presented while `stall`=1 is ignored;
  - LW to rd 0 → `dv` stays 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// corePckg: shared core types used by the load/store path.
//   tMemOp   - memory request produced by the ALU stage
//   tRegOp   - register-file write-back (dv, addr, data)
//   tAluOut  - ALU stage output bundle carrying memOp
//   tMemState, tMemErr, load/store funct3 constants for mem_access_unit
package corePckg;

  localparam int cXLEN     = 32;
  localparam int cRamDepth = 1024;
  localparam int cRegAddrW = 5;

  // Load/store funct3 encodings
  localparam logic [2:0] cLB  = 3'b000;
  localparam logic [2:0] cLH  = 3'b001;
  localparam logic [2:0] cLW  = 3'b010;
  localparam logic [2:0] cLBU = 3'b100;
  localparam logic [2:0] cLHU = 3'b101;
  localparam logic [2:0] cSB  = 3'b000;
  localparam logic [2:0] cSH  = 3'b001;
  localparam logic [2:0] cSW  = 3'b010;

  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [cXLEN-1:0]     addr;
    logic [2:0]           opType;
    logic [cXLEN-1:0]     data;
    logic [cRegAddrW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                 dv;
    logic [cRegAddrW-1:0] addr;
    logic [cXLEN-1:0]     data;
  } tRegOp;

  localparam tRegOp cRegOp = '0;

  typedef struct packed {
    tRegOp regOp;
    tMemOp memOp;
  } tAluOut;

  typedef enum logic {eMemIdle, eMemLoadWait} tMemState;

  typedef struct packed {
    logic             err;
    logic [cXLEN-1:0] addr;
  } tMemErr;

  // funct3 legality depends on direction: stores only know byte/half/word.
  function automatic logic isLegalOp(input logic isStore, input logic [2:0] opType);
    if (isStore)
      return (opType == cSB) || (opType == cSH) || (opType == cSW);
    return (opType == cLB) || (opType == cLH) || (opType == cLW) ||
           (opType == cLBU) || (opType == cLHU);
  endfunction

endpackage

// File: rtl/mem_access_unit_data_ram.sv
// data_ram: single-port synchronous RAM, 32-bit words with 4 byte-write
// enables. Read is registered (1 cycle) and read-first: a write and read on
// the same edge return the old word.
//   clk   - clock
//   en    - port enable (read and/or write this cycle)
//   we    - byte write enables, bit i covers wData[8i+7:8i]
//   addr  - word index
//   wData - write data
//   rData - registered read data
module data_ram #(
  parameter int pDepth = 1024,
  parameter int pAddrW = $clog2(pDepth)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [pAddrW-1:0] addr,
  input  logic [31:0]       wData,
  output logic [31:0]       rData
);

  // One byte-wide array per lane so each lane maps to its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic [7:0] mem [pDepth];
    logic [7:0] rdByteReg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) mem[addr] <= wData[gi*8 +: 8];
        rdByteReg <= mem[addr];
      end
    end

    assign rData[gi*8 +: 8] = rdByteReg;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory responder for the load/store path.
//   clk      - clock
//   rst      - synchronous active-high reset
//   memOpIn  - request (read/write act as valid, addr is a byte address)
//   regOpOut - registered load write-back, dv is a one-cycle pulse
//   stall    - high while a load is in flight
//   memErr   - one-cycle pulse after a rejected request
//   errAddr  - byte address of the last rejected request
module mem_access_unit
  import corePckg::*;
#(
  parameter int pDepth = cRamDepth,
  parameter int pAddrW = $clog2(pDepth)
) (
  input  logic             clk,
  input  logic             rst,
  input  tMemOp            memOpIn,
  output tRegOp            regOpOut,
  output logic             stall,
  output logic             memErr,
  output logic [cXLEN-1:0] errAddr
);

  tMemState             stateReg, stateNext;
  tRegOp                regOpReg;
  tMemErr               errReg;
  logic [cRegAddrW-1:0] rdAddrReg;
  logic [2:0]           opTypeReg;
  logic [1:0]           laneReg;

  logic        active, misaligned, outOfRange, reject, accept;
  logic        ramEn;
  logic [3:0]  ramWe, byteEn;
  logic [31:0] ramWData, ramRData, loadData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Request checks; only meaningful in IDLE.
  always_comb begin
    active     = memOpIn.read | memOpIn.write;
    misaligned = 1'b0;
    case (memOpIn.opType[1:0])
      2'b01:   misaligned = memOpIn.addr[0];
      2'b10:   misaligned = (memOpIn.addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    // Widen by one bit so the byte limit cannot overflow the compare.
    outOfRange = {1'b0, memOpIn.addr} >= ((cXLEN+1)'(pDepth) << 2);
    reject = !rst && (stateReg == eMemIdle) && active &&
             ((memOpIn.read && memOpIn.write) ||
              !isLegalOp(memOpIn.write, memOpIn.opType) ||
              misaligned || outOfRange);
    accept = !rst && (stateReg == eMemIdle) && active && !reject;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    byteEn   = 4'b1111;
    ramWData = memOpIn.data;
    case (memOpIn.opType[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << memOpIn.addr[1:0];
        ramWData = {4{memOpIn.data[7:0]}};
      end
      2'b01: begin
        byteEn   = memOpIn.addr[1] ? 4'b1100 : 4'b0011;
        ramWData = {2{memOpIn.data[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        ramWData = memOpIn.data;
      end
    endcase
  end

  // FSM next state and RAM port control.
  always_comb begin
    stateNext = stateReg;
    ramEn     = 1'b0;
    ramWe     = 4'b0000;
    case (stateReg)
      eMemIdle: begin
        ramEn = accept;
        if (accept && memOpIn.write) ramWe = byteEn;
        if (accept && memOpIn.read)  stateNext = eMemLoadWait;
      end
      eMemLoadWait: stateNext = eMemIdle;
      default:      stateNext = eMemIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) stateReg <= eMemIdle;
    else     stateReg <= stateNext;
  end

  data_ram #(.pDepth(pDepth), .pAddrW(pAddrW)) uDataRam (
    .clk   (clk),
    .en    (ramEn),
    .we    (ramWe),
    .addr  (memOpIn.addr[pAddrW+1:2]),
    .wData (ramWData),
    .rData (ramRData)
  );

  // Lane selection and extension of the word returned in LOAD_WAIT.
  always_comb begin
    laneByte = ramRData[{laneReg, 3'b000} +: 8];
    laneHalf = laneReg[1] ? ramRData[31:16] : ramRData[15:0];
    case (opTypeReg)
      cLB:     loadData = {{24{laneByte[7]}}, laneByte};
      cLBU:    loadData = {24'h0, laneByte};
      cLH:     loadData = {{16{laneHalf[15]}}, laneHalf};
      cLHU:    loadData = {16'h0, laneHalf};
      default: loadData = ramRData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regOpReg  <= cRegOp;
      errReg    <= '0;
      rdAddrReg <= '0;
      opTypeReg <= '0;
      laneReg   <= '0;
    end else begin
      regOpReg.dv <= 1'b0;
      errReg.err  <= reject;
      if (reject) errReg.addr <= memOpIn.addr;
      if (accept && memOpIn.read) begin
        rdAddrReg <= memOpIn.rdAddr;
        opTypeReg <= memOpIn.opType;
        laneReg   <= memOpIn.addr[1:0];
      end
      if (stateReg == eMemLoadWait) begin
        // x0 is never written back, but the RAM read still happened.
        regOpReg.dv   <= (rdAddrReg != '0);
        regOpReg.addr <= rdAddrReg;
        regOpReg.data <= loadData;
      end
    end
  end

  assign regOpOut = regOpReg;
  assign stall    = (stateReg == eMemLoadWait);
  assign memErr   = errReg.err;
  assign errAddr  = errReg.addr;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import corePckg::*;

  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  tMemOp       memOpIn = '0;
  tRegOp       regOpOut;
  logic        stall;
  logic        memErr;
  logic [31:0] errAddr;

  mem_access_unit #(.pDepth(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .memOpIn  (memOpIn),
    .regOpOut (regOpOut),
    .stall    (stall),
    .memErr   (memErr),
    .errAddr  (errAddr)
  );

  always #5 clk = ~clk;

  // Reference model: byte-addressed memory plus last error address.
  logic [7:0]  refMem [BYTES];
  logic [31:0] lastErr = '0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check the cycle(s) it takes. If junk is set a
  // legal store is presented while the load is stalled; it must be ignored.
  task automatic doReq(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] rdA, input bit junk);
    int  size;
    bit  legal, isLoad, isStore;
    logic [31:0] expData, w;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = 1;
    if (rd && wr)  legal = 0;
    else if (rd)   legal = (op == 0 || op == 1 || op == 2 || op == 4 || op == 5);
    else if (wr)   legal = (op == 0 || op == 1 || op == 2);
    if (a % size != 0) legal = 0;
    if (a >= BYTES)    legal = 0;
    isLoad  = rd && !wr && legal;
    isStore = wr && !rd && legal;
    expData = '0;
    if (isLoad) begin
      w = {refMem[(a & ~32'd3) + 3], refMem[(a & ~32'd3) + 2],
           refMem[(a & ~32'd3) + 1], refMem[a & ~32'd3]};
      case (op)
        3'd0: expData = 32'($signed(refMem[a]));
        3'd4: expData = {24'h0, refMem[a]};
        3'd1: expData = 32'($signed({refMem[a+1], refMem[a]}));
        3'd5: expData = {16'h0, refMem[a+1], refMem[a]};
        default: expData = w;
      endcase
    end
    if ((rd || wr) && !legal) lastErr = a;

    @(negedge clk);
    memOpIn = '{read: rd, write: wr, addr: a, opType: op, data: d, rdAddr: rdA};
    @(posedge clk); #1;
    check("memErr", 64'(memErr), 64'((rd || wr) && !legal));
    check("errAddr", 64'(errAddr), 64'(lastErr));
    check("stall", 64'(stall), 64'(isLoad));
    check("dv_c1", 64'(regOpOut.dv), 64'(0));
    if (isStore) begin
      for (int i = 0; i < size; i++) refMem[a + i] = d[i*8 +: 8];
    end
    memOpIn = '0;
    if (isLoad) begin
      if (junk)
        memOpIn = '{read: 1'b0, write: 1'b1, addr: 32'h40, opType: cSW,
                    data: 32'hDEADBEEF, rdAddr: 5'd0};
      @(posedge clk); #1;
      memOpIn = '0;
      check("dv_c2", 64'(regOpOut.dv), 64'(rdA != 0));
      check("stall_c2", 64'(stall), 64'(0));
      check("memErr_c2", 64'(memErr), 64'(0));
      if (rdA != 0) begin
        check("wbAddr", 64'(regOpOut.addr), 64'(rdA));
        check("wbData", 64'(regOpOut.data), 64'(expData));
      end
    end
    $display("req rd=%0b wr=%0b addr=%08h op=%0d data=%08h rdA=%0d legal=%0b exp=%08h",
             rd, wr, a, op, d, rdA, legal, expData);
  endtask

  initial begin
    int r;
    logic [31:0] a;
    logic [2:0]  op;
    for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_regOp", 64'(regOpOut), 64'(cRegOp));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_memErr", 64'(memErr), 64'(0));
    check("rst_errAddr", 64'(errAddr), 64'(0));
    rst = 1'b0;

    // Clear RAM so every later load has a defined value
    for (int w = 0; w < DEPTH; w++) doReq(0, 1, 32'(w * 4), cSW, 32'h0, 5'd0, 0);

    // Directed plan
    doReq(0, 1, 32'h10, cSW, 32'h80001234, 5'd0, 0);
    doReq(1, 0, 32'h10, cLW, 32'h0, 5'd5, 0);
    doReq(1, 0, 32'h13, cLB, 32'h0, 5'd6, 0);
    doReq(1, 0, 32'h13, cLBU, 32'h0, 5'd7, 0);
    doReq(1, 0, 32'h12, cLH, 32'h0, 5'd8, 0);
    doReq(1, 0, 32'h10, cLHU, 32'h0, 5'd9, 0);
    doReq(0, 1, 32'h31, cSB, 32'h000000AB, 5'd0, 0);
    doReq(1, 0, 32'h30, cLW, 32'h0, 5'd10, 0);
    doReq(1, 0, 32'h21, cLH, 32'h0, 5'd11, 0);
    doReq(0, 1, 32'h22, cSW, 32'h11111111, 5'd0, 0);
    doReq(1, 0, 32'(BYTES), cLW, 32'h0, 5'd12, 0);
    doReq(1, 0, 32'h20, 3'b011, 32'h0, 5'd13, 0);
    doReq(1, 1, 32'h24, cLW, 32'h22222222, 5'd14, 0);
    doReq(1, 0, 32'h20, cLW, 32'h0, 5'd15, 0);
    doReq(1, 0, 32'h10, cLW, 32'h0, 5'd16, 1);  // store to 0x40 during stall
    doReq(1, 0, 32'h40, cLW, 32'h0, 5'd17, 0);
    doReq(1, 0, 32'h10, cLW, 32'h0, 5'd0, 0);   // rd 0: no dv

    // Reset while in LOAD_WAIT
    @(negedge clk);
    memOpIn = '{read: 1'b1, write: 1'b0, addr: 32'h10, opType: cLW, data: 32'h0, rdAddr: 5'd7};
    @(posedge clk); #1;
    check("rstLw_stall", 64'(stall), 64'(1));
    memOpIn = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstLw_regOp", 64'(regOpOut), 64'(cRegOp));
    check("rstLw_stall2", 64'(stall), 64'(0));
    check("rstLw_memErr", 64'(memErr), 64'(0));
    check("rstLw_errAddr", 64'(errAddr), 64'(0));
    lastErr = '0;
    rst = 1'b0;
    $display("req reset during LOAD_WAIT");
    doReq(1, 0, 32'h10, cLW, 32'h0, 5'd7, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 9));
      a  = 32'($urandom_range(0, BYTES + 15));
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) op = (r < 5) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) begin
        if (op[1:0] == 2'd1) a = a & ~32'd1;
        else if (op[1:0] == 2'd2) a = a & ~32'd3;
      end
      doReq(r < 5 || r == 9, r >= 5, a, op, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
